fs_serial: RTL and testbench



---
 rtl/fs_serial.sv | 101 ++++++++++
 tb/tb_fs_serial.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_serial.sv
// fs_serial: bit-serial subtractor D = A - B - BI, LSB first, one bit per clock.
// Optional signed-overflow output ovf is enabled by defining FS_OVF_EN.
module fs_serial #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo
`ifdef FS_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [W-1:0]   sa, sb, sr;
    logic           br;
    logic [CW-1:0]  cnt;
    logic           dbit, br_next, load, last;
`ifdef FS_OVF_EN
    logic           a_msb, b_msb;
`endif

    // full-subtractor cell on bit 0 plus control decode
    always_comb begin
        dbit    = sa[0] ^ sb[0] ^ br;
        br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
        load    = start && (state != RUN);
        last    = (state == RUN) && (cnt == LAST);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next-state and handshake outputs
    always_comb begin
        state_next = state;
        busy       = (state == RUN);
        done       = (state == DONE);
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // operand/result shifters, borrow, counter and held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            sr  <= '0;
            br  <= 1'b0;
            cnt <= '0;
            d   <= '0;
            bo  <= 1'b0;
`ifdef FS_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= bi;
            cnt <= '0;
`ifdef FS_OVF_EN
            a_msb <= a[W-1];
            b_msb <= b[W-1];
`endif
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {dbit, sr[W-1:1]};
            br  <= br_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                d  <= {dbit, sr[W-1:1]};
                bo <= br_next;
`ifdef FS_OVF_EN
                ovf <= (a_msb ^ b_msb) & (a_msb ^ dbit);
`endif
            end
        end
    end
endmodule

// File: tb/tb_fs_serial.sv
// tb_fs_serial: scoreboard-based self-checking bench for fs_serial.
module tb_fs_serial;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bi = 1'b0;
    logic         busy, done, bo;
    logic [W-1:0] d;
`ifdef FS_OVF_EN
    logic         ovf;
`endif

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    fs_serial #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
        .busy(busy), .done(done), .d(d), .bo(bo)
`ifdef FS_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        exp_t e;
        logic [W:0] r;
        r     = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, z};
        e.d   = r[W-1:0];
        e.bo  = r[W];
        e.ovf = (x[W-1] ^ y[W-1]) & (x[W-1] ^ r[W-1]);
        return e;
    endfunction

    // drives start for one accepting edge and records the expected result
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        a = x; b = y; bi = z; start = 1'b1;
        sbq.push_back(model(x, y, z));
        tick;
        start = 1'b0;
        a = ~x; b = ~y; bi = ~z;
    endtask

    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 20 && !ok) begin
            tick;
            n++;
            ok = (done === 1'b1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        checks++;
        if ({busy, done, d, bo} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b d=%h bo=%b expected all zero", busy, done, d, bo);
        end
`ifdef FS_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: ovf=%b expected 0", ovf); end
`endif
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        exp_t e;
        issue(4'd9, 4'd3, 1'b0);
        for (int k = 0; k < W; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy[%0d]: busy=%b done=%b expected busy=1 done=0", k, busy, done);
            end
            tick;
        end
        e = sbq.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || d !== e.d || bo !== e.bo) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b d=%h bo=%b expected done=1 busy=0 d=%h bo=%b", done, busy, d, bo, e.d, e.bo);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || d !== e.d || bo !== e.bo) begin
            errors++;
            $display("FAIL basic_hold: done=%b busy=%b d=%h bo=%b expected done=0 busy=0 d=%h bo=%b", done, busy, d, bo, e.d, e.bo);
        end
    endtask

    task automatic test_patterns;
        exp_t e;
        int   n;
        bit   ok;
        logic [W-1:0] pa[8];
        logic [W-1:0] pb[8];
        logic         pi[8];
        pa[0] = 4'd3; pb[0] = 4'd9; pi[0] = 1'b0;
        pa[1] = 4'd0; pb[1] = 4'd0; pi[1] = 1'b1;
        pa[2] = 4'hF; pb[2] = 4'hF; pi[2] = 1'b1;
        pa[3] = 4'hF; pb[3] = 4'h0; pi[3] = 1'b0;
        for (int i = 4; i < 8; i++) begin
            pa[i] = W'($urandom); pb[i] = W'($urandom); pi[i] = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            issue(pa[i], pb[i], pi[i]);
            wait_done(n, ok);
            e = sbq.pop_front();
            checks++;
            if (!ok || d !== e.d || bo !== e.bo) begin
                errors++;
                $display("FAIL pattern[%0d] %h-%h-%b: done=%b d=%h bo=%b expected done=1 d=%h bo=%b", i, pa[i], pb[i], pi[i], ok, d, bo, e.d, e.bo);
            end
            tick;
        end
    endtask

    task automatic test_start_ignored;
        exp_t e;
        int   n, extra;
        bit   ok;
        issue(4'd12, 4'd5, 1'b1);
        tick;
        a = 4'd1; b = 4'd14; bi = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(n, ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || n != 2 || d !== e.d || bo !== e.bo) begin
            errors++;
            $display("FAIL start_ignored: done=%b after %0d d=%h bo=%b expected done=1 after 2 d=%h bo=%b", ok, n, d, bo, e.d, e.bo);
        end
        extra = 0;
        for (int k = 0; k < 2 * W; k++) begin
            tick;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_extra: extra_done=%0d busy=%b expected 0 and 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   n, extra;
        bit   ok;
        issue(4'd7, 4'd2, 1'b0);
        tick;
        #3 rst = 1'b1;
        #1;
        void'(sbq.pop_back());
        checks++;
        if ({busy, done, d, bo} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b d=%h bo=%b expected all zero", busy, done, d, bo);
        end
        tick;
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < W + 3; k++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: active_cycles=%0d expected 0", extra);
        end
        issue(4'd7, 4'd2, 1'b0);
        wait_done(n, ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || d !== e.d || bo !== e.bo) begin
            errors++;
            $display("FAIL reset_mid_after: done=%b d=%h bo=%b expected done=1 d=%h bo=%b", ok, d, bo, e.d, e.bo);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   n;
        bit   ok;
        issue(4'd10, 4'd4, 1'b0);
        wait_done(n, ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || d !== e.d || bo !== e.bo) begin
            errors++;
            $display("FAIL b2b_first: done=%b d=%h bo=%b expected done=1 d=%h bo=%b", ok, d, bo, e.d, e.bo);
        end
        a = 4'd5; b = 4'd5; bi = 1'b0; start = 1'b1;
        sbq.push_back(model(4'd5, 4'd5, 1'b0));
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        wait_done(n, ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || n != W || d !== e.d || bo !== e.bo) begin
            errors++;
            $display("FAIL b2b_second: done=%b after %0d d=%h bo=%b expected done=1 after %0d d=%h bo=%b", ok, n, d, bo, W, e.d, e.bo);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== e.d) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b d=%h expected 0 0 %h", busy, done, d, e.d);
        end
    endtask

    task automatic test_ovf;
        exp_t e;
        int   n;
        bit   ok;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) issue(4'b0111, 4'b1111, 1'b0);
            else        issue(4'd2, 4'd1, 1'b0);
            wait_done(n, ok);
            e = sbq.pop_front();
            checks++;
            if (!ok || d !== e.d || bo !== e.bo) begin
                errors++;
                $display("FAIL ovf_case[%0d]: done=%b d=%h bo=%b expected done=1 d=%h bo=%b", i, ok, d, bo, e.d, e.bo);
            end
`ifdef FS_OVF_EN
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("FAIL ovf_flag[%0d]: ovf=%b expected %b", i, ovf, e.ovf);
            end
`endif
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_patterns;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        test_ovf;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
